led_matrix_scanner: RTL
=======================

// Module: led_matrix_scanner
// PURPOSE
//  Parametrised multiplexed driver for a ROWS x COLS LED matrix with row anodes (active-high) and column cathodes (active-low).
//  Scans one row per slot, has a programmable scan prescaler, per-frame PWM brightness and a double-buffered pattern.
//  Updates are tear-free: a new pattern is applied only at a frame boundary.
//  Sits between pattern sources (dice/decoders) and the board pins; supersedes the fixed 3x3 slow-clock converter.
// PARAMETERS
//  ROWS   3   number of matrix rows (anode lines), >=1
//  COLS   3   number of matrix columns (cathode lines), >=1
//  DIV_W  24  width of scan prescaler reload value
//  PWM_W  3   brightness resolution; slot = 2**PWM_W subslots
// PORTS
//  clk         in   1          system clock; all logic on posedge
//  rst         in   1          synchronous reset, active-high
//  enable      in   1          1 = scan, 0 = blank and hold scan position at zero
//  tick_div    in   DIV_W      prescaler reload; one subslot = tick_div+1 clk cycles
//  brightness  in   PWM_W      on-subslots per row slot (0 = dark); sampled at frame start
//  pattern     in   ROWS*COLS  bit r*COLS+c = LED at row r, col c (1 = lit)
//  load        in   1          1-cycle strobe: capture pattern into pending buffer
//  pending     out  1          1 = captured pattern not yet applied
//  rows        out  ROWS       row anode drive, active-high, one-hot or zero
//  cols        out  COLS       column cathode drive, active-low
//  frame_done  out  1          1-cycle pulse at end of last subslot of row ROWS-1
// BEHAVIOUR
//  Reset: rows=0, cols='1, pending=0, frame_done=0, active/pending buffers=0, all counters=0, brightness latch=0.
//  States: IDLE (enable=0) and SCAN (enable=1).
//   IDLE->SCAN on the first cycle enable=1; the row 0 slot starts on that cycle.
//   SCAN->IDLE in the cycle after enable=0. Counters are cleared, outputs blank, pending and buffers are retained.
//  Prescaler: pcnt counts 0..tick_div; tick when pcnt==tick_div, then pcnt wraps to 0. tick_div=0 gives a tick every cycle.
//  Subslot counter s (PWM_W bits) advances on tick.
//   When s wraps from 2**PWM_W-1 to 0, row index r advances (ROWS-1 wraps to 0).
//  Frame length = ROWS * 2**PWM_W * (tick_div+1) cycles. tick_div changes take effect at the next pcnt wrap.
//  Drive: on = (s != 0) && (s <= bri_latched). Subslot 0 is always blank (anti-ghosting dead time).
//   rows[r]=on; all other rows 0.
//   cols[c] = ~(on & active[r*COLS+c]).
//   Outputs are registered: 1 cycle after the s/r state that produces them.
//  Duty = bri/2**PWM_W. Maximum brightness = (2**PWM_W-1)/2**PWM_W.
//  Load: on load=1, pending_buf<=pattern and pending<=1. A later load before the swap overwrites pending_buf (last wins).
//  Frame boundary = the tick that wraps r from ROWS-1 to 0. In that cycle:
//   - frame_done pulses.
//   - bri_latched<=brightness.
//   - if pending, active<=pending_buf and pending<=0.
//  Simultaneous load and frame boundary: the incoming pattern goes straight to active and pending<=0.
//  First frame after IDLE->SCAN: active and brightness latch are refreshed on the entry cycle, with the same pending rule.
//  rst mid-frame wins over everything: next cycle shows reset values.
// TESTING
//  1 Reset: assert rst 2 cycles mid-scan -> rows=0, cols=3'b111, pending=0, frame_done=0 on the following cycle.
//  2 Timing: ROWS=COLS=3, PWM_W=3, tick_div=0, bri=7, pattern=9'h1FF
//    -> frame_done every 24 cycles.
//    -> each row high 7 of 8 cycles, rows one-hot, cols=000 while on.
//  3 Brightness: bri=0 -> rows=0 for a whole frame. bri=2, tick_div=4 -> each row high for exactly 10 of 40 cycles.
//  4 Tear-free update: load 9'h155 mid-row-1 while 9'h0AA is active
//    -> pending=1 and 9'h0AA shown to frame end; 9'h155 from the next frame, pending=0.
//  5 Coincident: load 9'h007 on the frame-boundary cycle -> next frame shows 9'h007 and pending never rises.
//  6 Enable drop mid-row 2 -> blank next cycle. Re-enable -> scan restarts at row 0, s=0, with pending pattern applied.

Source files
------------

// File: rtl/led_matrix_scanner_if.sv
// Control and pin-side signals of the LED matrix scanner.
// The master drives pattern/control; the slave is the scanner.
interface led_matrix_scanner_if #(
   parameter int ROWS  = 3,
   parameter int COLS  = 3,
   parameter int DIV_W = 24,
   parameter int PWM_W = 3
);
   logic                 enable;
   logic [DIV_W-1:0]     tick_div;
   logic [PWM_W-1:0]     brightness;
   logic [ROWS*COLS-1:0] pattern;
   logic                 load;
   logic                 pending;
   logic [ROWS-1:0]      rows;
   logic [COLS-1:0]      cols;
   logic                 frame_done;

   modport master (
      output enable, tick_div, brightness, pattern, load,
      input  pending, rows, cols, frame_done
   );

   modport slave (
      input  enable, tick_div, brightness, pattern, load,
      output pending, rows, cols, frame_done
   );
endinterface

// File: rtl/led_matrix_scanner.sv
// Multiplexed ROWS x COLS LED matrix driver: row-per-slot scan, prescaled subslots,
// per-frame PWM brightness and a double-buffered pattern swapped only at frame boundaries.
module led_matrix_scanner #(
   parameter int ROWS  = 3,
   parameter int COLS  = 3,
   parameter int DIV_W = 24,
   parameter int PWM_W = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   led_matrix_scanner_if.slave   bus
);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int N  = ROWS * COLS;

   typedef enum logic {IDLE, SCAN} state_t;

   state_t           state_q;
   logic [DIV_W-1:0] pcnt_q;
   logic [DIV_W-1:0] div_q;
   logic [PWM_W-1:0] s_q;
   logic [RW-1:0]    r_q;
   logic [PWM_W-1:0] bri_q;
   logic [N-1:0]     active_q;
   logic [N-1:0]     pbuf_q;
   logic             pending_q;
   logic [ROWS-1:0]  rows_q;
   logic [COLS-1:0]  cols_q;
   logic             frame_done_q;

   logic [DIV_W-1:0] div_d;
   logic             tick;
   logic             s_wrap;
   logic             last_row;
   logic             boundary;
   logic             entry;
   logic             refresh;
   logic             on;
   logic [COLS-1:0]  row_bits;

   always_comb begin
      // The reload value is sampled at the start of each prescaler count and held.
      div_d    = (pcnt_q == '0) ? bus.tick_div : div_q;
      tick     = (pcnt_q == div_d);
      s_wrap   = (s_q == '1);
      last_row = (r_q == RW'(ROWS - 1));
      boundary = bus.enable && tick && s_wrap && last_row;
      entry    = bus.enable && (state_q == IDLE);
      refresh  = boundary || entry;
      on       = (s_q != '0) && (s_q <= bri_q);
      row_bits = active_q[r_q*COLS +: COLS];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         pcnt_q       <= '0;
         div_q        <= '0;
         s_q          <= '0;
         r_q          <= '0;
         bri_q        <= '0;
         active_q     <= '0;
         pbuf_q       <= '0;
         pending_q    <= 1'b0;
         rows_q       <= '0;
         cols_q       <= '1;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= boundary;
         if (!bus.enable) begin
            state_q <= IDLE;
            pcnt_q  <= '0;
            div_q   <= '0;
            s_q     <= '0;
            r_q     <= '0;
            rows_q  <= '0;
            cols_q  <= '1;
         end else begin
            state_q <= SCAN;
            div_q   <= div_d;
            if (tick) begin
               pcnt_q <= '0;
               s_q    <= s_q + 1'b1;
               if (s_wrap)
                  r_q <= last_row ? '0 : r_q + 1'b1;
            end else begin
               pcnt_q <= pcnt_q + 1'b1;
            end
            rows_q <= on ? (ROWS'(1) << r_q) : '0;
            cols_q <= on ? ~row_bits : '1;
         end

         if (bus.load)
            pbuf_q <= bus.pattern;
         // A load coinciding with a frame start bypasses the pending buffer.
         if (refresh) begin
            bri_q <= bus.brightness;
            if (bus.load) begin
               active_q  <= bus.pattern;
               pending_q <= 1'b0;
            end else if (pending_q) begin
               active_q  <= pbuf_q;
               pending_q <= 1'b0;
            end
         end else if (bus.load) begin
            pending_q <= 1'b1;
         end
      end
   end

   assign bus.pending    = pending_q;
   assign bus.rows       = rows_q;
   assign bus.cols       = cols_q;
   assign bus.frame_done = frame_done_q;
endmodule
